// File: rtl/counter_flag_multi.sv
// Multi-channel wrap counter with per-channel flag/LED outputs and
// shadowed terminal-count/mode configuration that takes effect on a wrap.
module counter_flag_multi #(
    parameter int               CH      = 4,
    parameter int               CNT_W   = 25,
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(24),
    parameter int               CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [CH-1:0]    en,
    input  logic             sync_clr,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_max,
    input  logic             cfg_mode,
    output logic [CH-1:0]    flag_out,
    output logic [CH-1:0]    led_out,
    output logic [CH-1:0]    cfg_pending
);

    // Writes addressed beyond the last channel are dropped here.
    logic cfg_ok;
    assign cfg_ok = cfg_we && (32'(cfg_ch) < CH);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_max;
        logic [CNT_W-1:0] sh_max;
        logic             act_mode;
        logic             sh_mode;
        logic             pend;
        logic             flag;
        logic             led;

        logic wr;
        logic wrap;
        logic apply;
        logic mode_chg;
        logic next_mode;

        assign wr        = cfg_ok && (32'(cfg_ch) == i);
        assign wrap      = en[i] && (cnt == act_max);
        // Only a shadow pending before this edge may apply; a write landing
        // on the same edge waits for the next opportunity.
        assign apply     = pend && !sync_clr && (wrap || !en[i]);
        assign mode_chg  = apply && (sh_mode != act_mode);
        assign next_mode = apply ? sh_mode : act_mode;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                cnt      <= '0;
                act_max  <= CNT_MAX;
                act_mode <= 1'b0;
                sh_max   <= CNT_MAX;
                sh_mode  <= 1'b0;
                pend     <= 1'b0;
                flag     <= 1'b0;
                led      <= 1'b0;
            end else begin
                if (sync_clr) begin
                    cnt  <= '0;
                    flag <= 1'b0;
                    led  <= 1'b0;
                end else if (en[i]) begin
                    flag <= wrap;
                    cnt  <= wrap ? '0 : cnt + 1'b1;
                    if (mode_chg)
                        led <= 1'b0;
                    else if (next_mode)
                        led <= wrap;
                    else if (wrap)
                        led <= ~led;
                end else begin
                    // Idle channel: toggle LED holds, pulse LED follows the
                    // (now low) flag.
                    flag <= 1'b0;
                    if (apply) begin
                        cnt <= '0;
                        led <= 1'b0;
                    end else if (act_mode) begin
                        led <= 1'b0;
                    end
                end

                if (apply) begin
                    act_max  <= sh_max;
                    act_mode <= sh_mode;
                end

                if (wr) begin
                    sh_max  <= cfg_max;
                    sh_mode <= cfg_mode;
                    pend    <= 1'b1;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        assign flag_out[i]    = flag;
        assign led_out[i]     = led;
        assign cfg_pending[i] = pend;
    end

endmodule

// File: tb/tb_counter_flag_multi.sv
// Bench for counter_flag_multi: directed scenarios plus randomized traffic,
// checked each cycle against a behavioural model.
module tb_counter_flag_multi;

    // Five channels so that cfg_ch has 3 bits and 5..7 are real out-of-range codes.
    localparam int CH    = 5;
    localparam int CNT_W = 25;
    localparam int CH_W  = 3;
    localparam int DEF   = 24;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [CH-1:0]    en;
    logic             sync_clr;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_max;
    logic             cfg_mode;
    logic [CH-1:0]    flag_out;
    logic [CH-1:0]    led_out;
    logic [CH-1:0]    cfg_pending;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    counter_flag_multi #(.CH(CH), .CNT_W(CNT_W), .CNT_MAX(CNT_W'(DEF))) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .sync_clr   (sync_clr),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_max    (cfg_max),
        .cfg_mode   (cfg_mode),
        .flag_out   (flag_out),
        .led_out    (led_out),
        .cfg_pending(cfg_pending)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural model: per-channel integers updated from the rules on each edge.
    int m_cnt [CH];
    int m_max [CH];
    int s_max [CH];
    bit m_mode[CH];
    bit s_mode[CH];
    bit m_pend[CH];
    bit m_flag[CH];
    bit m_led [CH];

    always @(posedge sys_clk) begin
        for (int i = 0; i < CH; i++) begin
            bit wrap;
            bit app;
            bit chg;
            if (sys_rst) begin
                m_cnt[i] = 0;  m_max[i] = DEF; s_max[i] = DEF;
                m_mode[i] = 0; s_mode[i] = 0;  m_pend[i] = 0;
                m_flag[i] = 0; m_led[i] = 0;
            end else begin
                if (sync_clr) begin
                    m_cnt[i] = 0; m_flag[i] = 0; m_led[i] = 0;
                end else begin
                    wrap = en[i] && (m_cnt[i] == m_max[i]);
                    app  = m_pend[i] && (wrap || !en[i]);
                    chg  = app && (s_mode[i] != m_mode[i]);
                    if (app) begin
                        m_max[i] = s_max[i]; m_mode[i] = s_mode[i]; m_pend[i] = 0;
                    end
                    m_flag[i] = wrap;
                    if (en[i])    m_cnt[i] = wrap ? 0 : m_cnt[i] + 1;
                    else if (app) m_cnt[i] = 0;
                    if ((app && !en[i]) || chg) m_led[i] = 0;
                    else if (m_mode[i])         m_led[i] = wrap;
                    else if (wrap)              m_led[i] = !m_led[i];
                end
                if (cfg_we && (int'(cfg_ch) == i)) begin
                    s_max[i] = int'(cfg_max); s_mode[i] = cfg_mode; m_pend[i] = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (chk_en) begin
            logic [CH-1:0] ef, el, ep;
            for (int i = 0; i < CH; i++) begin
                ef[i] = m_flag[i]; el[i] = m_led[i]; ep[i] = m_pend[i];
            end
            check("model_flag", 32'(flag_out), 32'(ef));
            check("model_led", 32'(led_out), 32'(el));
            check("model_pending", 32'(cfg_pending), 32'(ep));
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_flag(input int ch, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (flag_out[ch] !== 1'b1 && n < budget);
    endtask

    task automatic cfg_write(input int ch, input int mx, input bit md);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_max = CNT_W'(mx); cfg_mode = md;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int n;
        logic prev;
        sys_rst = 1'b1; en = '0; sync_clr = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_max = '0; cfg_mode = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_flag", 32'(flag_out), 0);
        check("rst_led", 32'(led_out), 0);
        check("rst_pending", 32'(cfg_pending), 0);

        // Default period 25 after reset release.
        sys_rst = 1'b0; en = '1;
        wait_flag(0, 60, n);
        check("def_first_wrap", n, 25);
        check("def_led_on", 32'(led_out[0]), 1);
        wait_flag(0, 60, n);
        check("def_second_wrap", n, 25);
        check("def_led_off", 32'(led_out[0]), 0);

        // Shadow max on an enabled channel waits for the current wrap.
        repeat (5) tick();
        cfg_write(1, 9, 1'b0);
        check("ch1_pending_set", 32'(cfg_pending[1]), 1);
        wait_flag(1, 60, n);
        check("ch1_old_wrap", n, 19);
        check("ch1_pending_clr", 32'(cfg_pending[1]), 0);
        wait_flag(1, 60, n);
        check("ch1_new_period", n, 10);

        // Disabled channel picks up the shadow one edge after the write.
        en[2] = 1'b0;
        cfg_write(2, 3, 1'b1);
        check("ch2_pending_set", 32'(cfg_pending[2]), 1);
        tick();
        check("ch2_applied", 32'(cfg_pending[2]), 0);
        check("ch2_led_zero", 32'(led_out[2]), 0);
        en[2] = 1'b1;
        wait_flag(2, 60, n);
        check("ch2_first_pulse", n, 4);
        check("ch2_led_pulse", 32'(led_out[2]), 1);
        wait_flag(2, 60, n);
        check("ch2_period", n, 4);

        // max=0: flag held high, LED toggles each cycle; out-of-range writes ignored.
        cfg_write(3, 0, 1'b0);
        wait_flag(3, 60, n);
        check("ch3_reached_wrap", 32'(flag_out[3]), 1);
        for (int k = 5; k < 8; k++) begin
            prev = led_out[3];
            cfg_write(k, 1, 1'b1);
            check("ch3_flag_const", 32'(flag_out[3]), 1);
            check("ch3_led_toggle", 32'(led_out[3]), 32'(!prev));
        end
        check("oor_no_pending", 32'(cfg_pending), 0);

        // Write captured alongside sync_clr, applied at the next natural wrap.
        repeat (7) tick();
        sync_clr = 1'b1;
        cfg_write(0, 4, 1'b1);
        sync_clr = 1'b0;
        check("clr_flag", 32'(flag_out), 0);
        check("clr_led", 32'(led_out), 0);
        check("clr_pending_kept", 32'(cfg_pending[0]), 1);
        wait_flag(0, 60, n);
        check("clr_wrap_after", n, 25);
        check("clr_mode_chg_led", 32'(led_out[0]), 0);
        check("clr_pending_clr", 32'(cfg_pending[0]), 0);
        wait_flag(0, 60, n);
        check("clr_new_period", n, 5);
        check("clr_pulse_led", 32'(led_out[0]), 1);

        // Reset while pending and counting restores defaults.
        cfg_write(1, 2, 1'b1);
        sys_rst = 1'b1;
        tick();
        check("rst2_flag", 32'(flag_out), 0);
        check("rst2_led", 32'(led_out), 0);
        check("rst2_pending", 32'(cfg_pending), 0);
        sys_rst = 1'b0;
        wait_flag(0, 60, n);
        check("rst2_first_wrap", n, 25);
        check("rst2_led_toggle", 32'(led_out[0]), 1);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            en       = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
            sync_clr = ($urandom_range(0, 63) == 0);
            sys_rst  = ($urandom_range(0, 399) == 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 7));
            cfg_max  = ($urandom_range(0, 15) == 0) ? CNT_W'(DEF) : CNT_W'($urandom_range(0, 7));
            cfg_mode = 1'($urandom_range(0, 1));
            tick();
        end
        cfg_we = 1'b0; sync_clr = 1'b0; sys_rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
